// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and helper definitions for the ALU arbiter slice.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_PASS = 3'b000;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [OP_W-1:0] OP_AND  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Opcodes 110 and 111 are reserved and flagged as illegal.
    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op == 3'b110) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Registered ALU: one-cycle latency, loads on 'load', illegal opcodes yield zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [OPW-1:0] op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   result,
    output logic           illegal
);

    logic [OP_W-1:0] op_n;
    logic [N-1:0]    result_c;
    logic            illegal_c;

    assign op_n = OP_W'(op);

    // Combinational opcode decode; arithmetic wraps modulo 2^N.
    always_comb begin
        result_c  = '0;
        illegal_c = is_illegal_op(op_n);
        case (op_n)
            OP_PASS: result_c = a;
            OP_NOT:  result_c = ~a;
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_OR:   result_c = a | b;
            OP_AND:  result_c = a & b;
            default: result_c = '0;
        endcase
    end

    // Result register; holds its value between loads so the response stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            illegal <= 1'b0;
        end else if (load) begin
            result  <= result_c;
            illegal <= illegal_c;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two valid/ready requesters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [N-1:0]   resp_result,
    output logic           resp_illegal,
    output logic           busy
);

    state_t         state_q;
    state_t         state_d;
    logic           last_grant_q;
    logic           grant_c;
    logic           accept_c;
    logic           alu_load_c;
    logic [OPW-1:0] op_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           id_q;

    // Grant pick and next-state logic; grant alternates only under contention.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        alu_load_c = 1'b0;
        grant_c    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else begin
            grant_c = req1_valid;
        end
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_c = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_load_c = 1'b1;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is a combinational handshake qualifier, only ever raised in IDLE.
    assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant_c;
    assign req1_ready = (state_q == S_IDLE) && req1_valid &&  grant_c;

    // State, grant pointer, operand/id latches and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            resp_valid   <= 1'b0;
            busy         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_valid <= (state_d == S_RESP);
            busy       <= (state_d != S_IDLE);
            if (accept_c) begin
                last_grant_q <= grant_c;
                id_q         <= grant_c;
                op_q         <= grant_c ? req1_op : req0_op;
                a_q          <= grant_c ? req1_a  : req0_a;
                b_q          <= grant_c ? req1_b  : req0_b;
            end
        end
    end

    assign resp_id = id_q;

    alu_core #(
        .N   (N),
        .OPW (OPW)
    ) u_alu_core (
        .clk     (clk),
        .rst     (rst),
        .load    (alu_load_c),
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .result  (resp_result),
        .illegal (resp_illegal)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_illegal, busy;
    logic [31:0] resp_result;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        illegal;
    } rsp_t;

    req_t pend0[$];
    req_t pend1[$];
    rsp_t exp_q[$];
    int   vec  = 0;
    int   miss = 0;
    bit   a0, a1, r0s, r1s;

    always #5 clk = ~clk;

    alu_arbiter #(.N(32), .OPW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_illegal (resp_illegal),
        .busy         (busy)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'b000:  return a;
            3'b001:  return ~a;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a | b;
            3'b101:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (pend0.size() > 0) begin
            req0_valid = 1'b1;
            req0_op    = pend0[0].op;
            req0_a     = pend0[0].a;
            req0_b     = pend0[0].b;
        end else begin
            req0_valid = 1'b0;
        end
        if (pend1.size() > 0) begin
            req1_valid = 1'b1;
            req1_op    = pend1[0].op;
            req1_a     = pend1[0].a;
            req1_b     = pend1[0].b;
        end else begin
            req1_valid = 1'b0;
        end
    endtask

    task automatic issue(input bit id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        req_t r;
        r.op = op;
        r.a  = a;
        r.b  = b;
        if (id) pend1.push_back(r);
        else    pend0.push_back(r);
        drive();
    endtask

    task automatic expect_rsp(input bit id, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        rsp_t e;
        e.id      = id;
        e.illegal = (op == 3'b110) || (op == 3'b111);
        e.result  = model(op, a, b);
        exp_q.push_back(e);
    endtask

    // One clock: sample at negedge, check any response handshake, drive after posedge.
    task automatic step();
        rsp_t e;
        @(negedge clk);
        r0s = req0_ready;
        r1s = req1_ready;
        a0  = !rst && req0_valid && req0_ready;
        a1  = !rst && req1_valid && req1_ready;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_result", resp_result, e.result);
                chk("resp_illegal", 32'(resp_illegal), 32'(e.illegal));
            end
        end
        @(posedge clk);
        #1;
        if (a0 && pend0.size() > 0) void'(pend0.pop_front());
        if (a1 && pend1.size() > 0) void'(pend1.pop_front());
        drive();
    endtask

    task automatic settle(input string tag, input int budget);
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size() + pend0.size() + pend1.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        step();
        step();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_illegal", 32'(resp_illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single add from req0: ready at once, response two cycles later.
        issue(0, 3'b010, 32'd5, 32'd7);
        expect_rsp(0, 3'b010, 32'd5, 32'd7);
        step();
        chk("t1_ready", 32'(r0s), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_rv_early", 32'(resp_valid), 32'd0);
        step();
        chk("t1_rv", 32'(resp_valid), 32'd1);
        chk("t1_result", resp_result, 32'd12);
        chk("t1_id", 32'(resp_id), 32'd0);
        settle("t1", 20);

        // Addition wraps modulo 2^32.
        issue(0, 3'b010, 32'hFFFF_FFFF, 32'd1);
        expect_rsp(0, 3'b010, 32'hFFFF_FFFF, 32'd1);
        settle("wrap", 20);

        // Both valid at reset exit: req0 wins first contention.
        rst = 1'b1;
        issue(0, 3'b011, 32'd3, 32'd5);
        issue(1, 3'b101, 32'h0000_00F0, 32'h0000_003C);
        expect_rsp(0, 3'b011, 32'd3, 32'd5);
        expect_rsp(1, 3'b101, 32'h0000_00F0, 32'h0000_003C);
        step();
        step();
        rst = 1'b0;
        settle("t2", 30);

        // Continuous contention alternates grants 0,1,0,1.
        issue(0, 3'b000, 32'h0000_0011, 32'd0);
        issue(0, 3'b100, 32'h0000_00F0, 32'h0000_000F);
        issue(1, 3'b001, 32'h0000_FFFF, 32'd0);
        issue(1, 3'b010, 32'h7FFF_FFFF, 32'd1);
        expect_rsp(0, 3'b000, 32'h0000_0011, 32'd0);
        expect_rsp(1, 3'b001, 32'h0000_FFFF, 32'd0);
        expect_rsp(0, 3'b100, 32'h0000_00F0, 32'h0000_000F);
        expect_rsp(1, 3'b010, 32'h7FFF_FFFF, 32'd1);
        settle("t3", 40);

        // Illegal opcodes still produce a tagged, zero-result response.
        issue(1, 3'b111, 32'h0000_1234, 32'h0000_5678);
        expect_rsp(1, 3'b111, 32'h0000_1234, 32'h0000_5678);
        settle("t4a", 20);
        issue(0, 3'b110, 32'd1, 32'd2);
        expect_rsp(0, 3'b110, 32'd1, 32'd2);
        settle("t4b", 20);

        // Back-pressure in RESP: outputs hold and no requester is readied.
        resp_ready = 1'b0;
        issue(1, 3'b100, 32'h0000_00A5, 32'h0000_05A0);
        issue(0, 3'b011, 32'd0, 32'd1);
        expect_rsp(1, 3'b100, 32'h0000_00A5, 32'h0000_05A0);
        expect_rsp(0, 3'b011, 32'd0, 32'd1);
        for (int i = 0; i < 10 && !resp_valid; i++) step();
        chk("t5_rv", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_rv", 32'(resp_valid), 32'd1);
            chk("t5_hold_result", resp_result, 32'h0000_05A5);
            chk("t5_hold_id", 32'(resp_id), 32'd1);
            chk("t5_ready0", 32'(r0s), 32'd0);
            chk("t5_ready1", 32'(r1s), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        chk("t5_idle", 32'(busy), 32'd0);
        settle("t5", 20);

        // Reset during EXEC drops the transaction; req0 wins afterwards.
        issue(1, 3'b010, 32'd1, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (a1) break;
        end
        chk("t6_accept", 32'(a1), 32'd1);
        chk("t6_busy_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rv", 32'(resp_valid), 32'd0);
        issue(0, 3'b010, 32'h0000_0100, 32'h0000_0200);
        issue(1, 3'b011, 32'h0000_0010, 32'h0000_0020);
        expect_rsp(0, 3'b010, 32'h0000_0100, 32'h0000_0200);
        expect_rsp(1, 3'b011, 32'h0000_0010, 32'h0000_0020);
        step();
        rst = 1'b0;
        settle("t6", 30);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
